// File: rtl/arith_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : arith_seq_ctrl_if
// Brief    : Request/result bundle between datapath control and arith_seq_ctrl.
//            ARITH_SEQ_OVF_EN adds the signed-overflow flag.
// Revision : 1.0  initial release
// ============================================================================
interface arith_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [1:0]             s;
    logic                   c_in;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   ready;
    logic                   done;
    logic [4*NIBBLES-1:0]   result;
    logic                   c_out;
`ifdef ARITH_SEQ_OVF_EN
    logic                   ovf;
`endif

    modport master (
        output start, s, c_in, a, b,
`ifdef ARITH_SEQ_OVF_EN
        input  ovf,
`endif
        input  ready, done, result, c_out
    );

    modport slave (
        input  start, s, c_in, a, b,
`ifdef ARITH_SEQ_OVF_EN
        output ovf,
`endif
        output ready, done, result, c_out
    );
endinterface
`default_nettype wire

// File: rtl/arith_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arith_seq_ctrl
// Brief    : Runs W-bit add/sub/inc/dec/transfer on a 4-bit arithmetic unit,
//            one nibble per cycle LSB first. ARITH_SEQ_OVF_EN adds ovf.
// Revision : 1.0  initial release
// ============================================================================
module arith_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire              clk,
    input  wire              rst,
    arith_seq_ctrl_if.slave  ctl,
    output logic [3:0]       au_a,
    output logic [3:0]       au_b,
    output logic [1:0]       au_s,
    output logic             au_cin,
    input  wire  [3:0]       au_d,
    input  wire              au_cout
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [1:0]        s_q, s_d;
    logic [W-1:0]      result_q, result_d;
    logic              c_out_q, c_out_d;
`ifdef ARITH_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
    logic              w_beff_msb;
`endif
    logic              w_ready;
    logic              w_accept;

    assign w_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_accept = w_ready && ctl.start;

`ifdef ARITH_SEQ_OVF_EN
    // Sign bit of the B operand as the unit actually sees it for this select.
    always_comb begin
        w_beff_msb = 1'b0;
        case (s_q)
            2'b00:   w_beff_msb = b_q[W-1];
            2'b01:   w_beff_msb = ~b_q[W-1];
            2'b10:   w_beff_msb = 1'b0;
            default: w_beff_msb = 1'b1;
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        result_d = result_q;
        c_out_d  = c_out_q;
`ifdef ARITH_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        au_a     = 4'd0;
        au_b     = 4'd0;
        au_s     = 2'd0;
        au_cin   = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
                au_a   = a_q[4*idx_q +: 4];
                au_b   = b_q[4*idx_q +: 4];
                au_s   = s_q;
                au_cin = carry_q;
                result_d[4*idx_q +: 4] = au_d;
                carry_d = au_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == C_LAST_IDX) begin
                    c_out_d = au_cout;
`ifdef ARITH_SEQ_OVF_EN
                    // Carry into the sign bit xor carry out of it.
                    ovf_d   = au_cout ^ (a_q[W-1] ^ w_beff_msb ^ au_d[3]);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Acceptance from IDLE or DONE overrides the hold/return above.
        if (w_accept) begin
            a_d      = ctl.a;
            b_d      = ctl.b;
            s_d      = ctl.s;
            carry_d  = ctl.c_in;
            idx_d    = '0;
            result_d = '0;
            c_out_d  = 1'b0;
`ifdef ARITH_SEQ_OVF_EN
            ovf_d    = 1'b0;
`endif
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= 2'd0;
            result_q <= '0;
            c_out_q  <= 1'b0;
`ifdef ARITH_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
`ifdef ARITH_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ctl.ready  = w_ready;
    assign ctl.done   = (state_q == ST_DONE);
    assign ctl.result = result_q;
    assign ctl.c_out  = c_out_q;
`ifdef ARITH_SEQ_OVF_EN
    assign ctl.ovf    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_seq_ctrl
// Brief    : Randomized self-checking bench for arith_seq_ctrl (NIBBLES=4 and 1)
//            against a whole-word arithmetic reference. Honours ARITH_SEQ_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_arith_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit arithmetic unit: D = A + Beff + C_in.
    function automatic logic [4:0] au_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] s, input logic cin);
        logic [3:0] beff;
        case (s)
            2'b00:   beff = b;
            2'b01:   beff = ~b;
            2'b10:   beff = 4'h0;
            default: beff = 4'hF;
        endcase
        return {1'b0, a} + {1'b0, beff} + {4'd0, cin};
    endfunction

    arith_seq_ctrl_if #(.NIBBLES(4)) ctl4 ();
    logic [3:0] au_a4, au_b4, au_d4;
    logic [1:0] au_s4;
    logic       au_cin4, au_cout4;
    assign {au_cout4, au_d4} = au_model(au_a4, au_b4, au_s4, au_cin4);

    arith_seq_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .ctl(ctl4),
        .au_a(au_a4), .au_b(au_b4), .au_s(au_s4), .au_cin(au_cin4),
        .au_d(au_d4), .au_cout(au_cout4)
    );

    arith_seq_ctrl_if #(.NIBBLES(1)) ctl1 ();
    logic [3:0] au_a1, au_b1, au_d1;
    logic [1:0] au_s1;
    logic       au_cin1, au_cout1;
    assign {au_cout1, au_d1} = au_model(au_a1, au_b1, au_s1, au_cin1);

    arith_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .ctl(ctl1),
        .au_a(au_a1), .au_b(au_b1), .au_s(au_s1), .au_cin(au_cin1),
        .au_d(au_d1), .au_cout(au_cout1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: result = A + Beff + c_in mod 2^w.
    function automatic void ref_op(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] s, input logic cin, input int w,
                                   output logic [63:0] res, output logic co, output logic ov);
        logic [64:0] mask, beff, sum;
        mask = (65'd1 << w) - 65'd1;
        case (s)
            2'b00:   beff = {1'b0, b} & mask;
            2'b01:   beff = ~{1'b0, b} & mask;
            2'b10:   beff = '0;
            default: beff = mask;
        endcase
        sum = ({1'b0, a} & mask) + beff + {64'd0, cin};
        res = 64'(sum & mask);
        co  = sum[w];
        ov  = (a[w-1] == beff[w-1]) && (res[w-1] != a[w-1]);
    endfunction

    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                          input logic cin, input bit noise, input bit hold);
        logic [63:0] er;
        logic        ec, eo;
        ref_op({48'd0, a}, {48'd0, b}, s, cin, 16, er, ec, eo);
        ctl4.a = a; ctl4.b = b; ctl4.s = s; ctl4.c_in = cin; ctl4.start = 1'b1;
        @(posedge clk); #1;
        chk("run_ready", ctl4.ready, 0);
        chk("run_au0", {au_a4, au_b4, au_s4, au_cin4}, {a[3:0], b[3:0], s, cin});
        for (int i = 0; i < 4; i++) begin
            if (noise) begin
                ctl4.start = 1'($urandom); ctl4.a = 16'($urandom); ctl4.b = 16'($urandom);
                ctl4.s = 2'($urandom); ctl4.c_in = 1'($urandom);
            end else begin
                ctl4.start = 1'b0;
            end
            @(posedge clk); #1;
            if (i < 3) chk("run_done", ctl4.done, 0);
        end
        ctl4.start = 1'b0;
        chk("done", ctl4.done, 1);
        chk("done_ready", ctl4.ready, 1);
        chk("result", ctl4.result, er);
        chk("c_out", ctl4.c_out, ec);
        chk("done_au", {au_a4, au_b4, au_s4, au_cin4}, 0);
`ifdef ARITH_SEQ_OVF_EN
        chk("ovf", ctl4.ovf, eo);
`endif
        if (hold) begin
            @(posedge clk); #1;
            chk("idle_done", ctl4.done, 0);
            chk("held_result", {ctl4.c_out, ctl4.result}, {ec, er[15:0]});
        end
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                          input logic cin);
        logic [63:0] er;
        logic        ec, eo;
        ref_op({60'd0, a}, {60'd0, b}, s, cin, 4, er, ec, eo);
        ctl1.a = a; ctl1.b = b; ctl1.s = s; ctl1.c_in = cin; ctl1.start = 1'b1;
        @(posedge clk); #1;
        ctl1.start = 1'b0;
        chk("n1_run", {ctl1.ready, ctl1.done, au_a1}, {2'b00, a});
        @(posedge clk); #1;
        chk("n1_done", ctl1.done, 1);
        chk("n1_result", {ctl1.c_out, ctl1.result}, {ec, er[3:0]});
`ifdef ARITH_SEQ_OVF_EN
        chk("n1_ovf", ctl1.ovf, eo);
`endif
    endtask

    initial begin
        ctl4.start = 0; ctl4.a = 0; ctl4.b = 0; ctl4.s = 0; ctl4.c_in = 0;
        ctl1.start = 0; ctl1.a = 0; ctl1.b = 0; ctl1.s = 0; ctl1.c_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_done", {ctl4.ready, ctl4.done}, 2'b10);
        chk("rst_result", {ctl4.c_out, ctl4.result}, 0);
        chk("rst_au", {au_a4, au_b4, au_s4, au_cin4}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op4(16'h1234, 16'h0FFF, 2'b00, 1'b0, 0, 1);   // add
        do_op4(16'h0005, 16'h0007, 2'b01, 1'b1, 0, 1);   // sub with borrow
        do_op4(16'h0007, 16'h0005, 2'b01, 1'b1, 0, 1);   // sub
        do_op4(16'hFFFF, 16'h0000, 2'b10, 1'b1, 0, 1);   // inc wrap
        do_op4(16'h0000, 16'h0000, 2'b11, 1'b0, 0, 1);   // dec wrap
        do_op4(16'hA5C3, 16'h1234, 2'b10, 1'b0, 0, 1);   // transfer A
        do_op4(16'h7FFF, 16'h0001, 2'b00, 1'b0, 0, 1);   // signed overflow
        do_op4(16'h1111, 16'h2222, 2'b00, 1'b0, 0, 0);   // back-to-back pair
        do_op4(16'h8000, 16'h8000, 2'b00, 1'b1, 1, 1);   // RUN-time noise ignored

        // Reset asserted in the second RUN cycle aborts the op.
        ctl4.a = 16'hFFFF; ctl4.b = 16'h0001; ctl4.s = 2'b00; ctl4.c_in = 1'b0; ctl4.start = 1'b1;
        @(posedge clk); #1;
        ctl4.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready_done", {ctl4.ready, ctl4.done}, 2'b10);
        chk("abort_result", {ctl4.c_out, ctl4.result}, 0);
        chk("abort_au", {au_a4, au_b4, au_s4, au_cin4}, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", ctl4.done, 0);
        end

        for (int n = 0; n < 40; n++)
            do_op4(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
        @(posedge clk); #1;

        do_op1(4'h9, 4'h8, 2'b00, 1'b0);
        do_op1(4'h0, 4'h0, 2'b11, 1'b0);
        for (int n = 0; n < 20; n++)
            do_op1(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
